// File: rtl/bp_io_uc_cce_pkg.sv
// Shared types for the uncached I/O engine: message layouts, type codes and FSM states.
package bp_io_uc_cce_pkg;

  localparam int paddr_width_p     = 40;
  localparam int dword_width_p     = 64;
  localparam int cce_block_width_p = 128;
  localparam int lce_id_width_p    = 4;
  localparam int cce_id_width_p    = 4;

  typedef enum logic [1:0] {
    e_lce_req_type_rd    = 2'b00,
    e_lce_req_type_wr    = 2'b01,
    e_lce_req_type_uc_rd = 2'b10,
    e_lce_req_type_uc_wr = 2'b11
  } bp_lce_cce_req_type_e;

  typedef enum logic [2:0] {
    e_mem_msg_size_1  = 3'd0,
    e_mem_msg_size_2  = 3'd1,
    e_mem_msg_size_4  = 3'd2,
    e_mem_msg_size_8  = 3'd3,
    e_mem_msg_size_16 = 3'd4,
    e_mem_msg_size_32 = 3'd5,
    e_mem_msg_size_64 = 3'd6
  } bp_mem_msg_size_e;

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'd0,
    e_cce_mem_wr    = 4'd1,
    e_cce_mem_uc_rd = 4'd2,
    e_cce_mem_uc_wr = 4'd3
  } bp_cce_mem_cmd_type_e;

  typedef enum logic [3:0] {
    e_lce_cmd_sync       = 4'b0000,
    e_lce_cmd_uc_data    = 4'b1000,
    e_lce_cmd_uc_st_done = 4'b1001
  } bp_lce_cmd_type_e;

  typedef struct packed {
    bp_mem_msg_size_e            size;
    logic [paddr_width_p-1:0]    addr;
    logic [lce_id_width_p-1:0]   src_id;
    logic [cce_id_width_p-1:0]   dst_id;
    bp_lce_cce_req_type_e        msg_type;
  } bp_lce_cce_req_header_s;

  typedef struct packed {
    logic [dword_width_p-1:0] data;
    bp_lce_cce_req_header_s   header;
  } bp_lce_cce_req_s;

  typedef struct packed {
    logic [lce_id_width_p-1:0] lce_id;
  } bp_cce_mem_payload_s;

  typedef struct packed {
    logic [cce_block_width_p-1:0] data;
    bp_cce_mem_payload_s          payload;
    bp_mem_msg_size_e             size;
    logic [paddr_width_p-1:0]     addr;
    bp_cce_mem_cmd_type_e         msg_type;
  } bp_cce_mem_msg_s;

  typedef struct packed {
    logic [cce_block_width_p-1:0] data;
    bp_mem_msg_size_e             size;
    logic [paddr_width_p-1:0]     addr;
    logic [lce_id_width_p-1:0]    dst_id;
    bp_lce_cmd_type_e             msg_type;
  } bp_lce_cmd_s;

  localparam int lce_cce_req_width_lp = $bits(bp_lce_cce_req_s);
  localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);
  localparam int lce_cmd_width_lp     = $bits(bp_lce_cmd_s);

  typedef enum logic [1:0] {
    E_READY        = 2'd0,
    E_SEND_CMD     = 2'd1,
    E_WAIT_RESP    = 2'd2,
    E_SEND_LCE_CMD = 2'd3
  } bp_io_uc_state_e;

  function automatic logic [cce_block_width_p-1:0] dword_to_block(input logic [dword_width_p-1:0] d);
    return {{(cce_block_width_p-dword_width_p){1'b0}}, d};
  endfunction

endpackage

// File: rtl/bp_io_uc_cce_timeout.sv
// Clearable up-counter that parks at max_val_p-1 and flags terminal count there.
module bp_io_uc_timeout #(
  parameter int max_val_p = 1024
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int cnt_width_lp = (max_val_p > 2) ? $clog2(max_val_p) : 1;

  logic [cnt_width_lp-1:0] cnt_r;

  assign tc_o = (cnt_r == cnt_width_lp'(max_val_p-1));

  // Count while enabled; hold at terminal so a deferred timeout still fires next cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)          cnt_r <= '0;
    else if (clear_i)        cnt_r <= '0;
    else if (en_i && !tc_o)  cnt_r <= cnt_r + 1'b1;
  end

endmodule

// File: rtl/bp_io_uc_cce.sv
// Uncached I/O engine: one LCE request -> one I/O command -> one LCE completion.
//
// state          | meaning
// E_READY        | idle, accept an uncached LCE request
// E_SEND_CMD     | present the I/O memory command until accepted
// E_WAIT_RESP    | wait for the device response or the timeout
// E_SEND_LCE_CMD | present the LCE completion until accepted
module bp_io_uc_cce
  import bp_io_uc_cce_pkg::*;
#(
  parameter int timeout_cycles_p = 1024,
  parameter int stale_max_p      = 7
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [cce_id_width_p-1:0]       cce_id_i,
  input  logic [lce_cce_req_width_lp-1:0] lce_req_i,
  input  logic                            lce_req_v_i,
  output logic                            lce_req_yumi_o,
  output logic [lce_cmd_width_lp-1:0]     lce_cmd_o,
  output logic                            lce_cmd_v_o,
  input  logic                            lce_cmd_ready_i,
  output logic [cce_mem_msg_width_lp-1:0] io_cmd_o,
  output logic                            io_cmd_v_o,
  input  logic                            io_cmd_ready_i,
  input  logic [cce_mem_msg_width_lp-1:0] io_resp_i,
  input  logic                            io_resp_v_i,
  output logic                            io_resp_yumi_o,
  output logic                            busy_o,
  output logic                            timeout_o
);

  localparam int stale_width_lp = $clog2(stale_max_p+1);
  localparam logic [stale_width_lp-1:0] stale_max_lp = stale_width_lp'(stale_max_p);

  bp_lce_cce_req_s lce_req;
  bp_cce_mem_msg_s io_resp, io_cmd;
  bp_lce_cmd_s     lce_cmd;

  assign lce_req = lce_req_i;
  assign io_resp = io_resp_i;

  bp_io_uc_state_e            state_r, state_n;
  bp_lce_cce_req_s            req_r;
  logic [dword_width_p-1:0]   resp_data_r;
  logic [stale_width_lp-1:0]  stale_r;
  logic                       timeout_r;

  logic req_yumi, resp_yumi, resp_capture, timeout_hit, stale_dec;
  logic to_clear, to_en, to_tc;

  bp_io_uc_timeout #(.max_val_p(timeout_cycles_p)) timer (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (to_clear),
    .en_i      (to_en),
    .tc_o      (to_tc)
  );

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= E_READY;
    else            state_r <= state_n;
  end

  // Next state and handshakes; a valid response always beats a coincident timeout.
  always_comb begin
    state_n      = state_r;
    req_yumi     = 1'b0;
    resp_yumi    = 1'b0;
    resp_capture = 1'b0;
    timeout_hit  = 1'b0;
    to_clear     = 1'b0;
    to_en        = 1'b0;
    io_cmd_v_o   = 1'b0;
    lce_cmd_v_o  = 1'b0;
    case (state_r)
      E_READY: begin
        req_yumi = lce_req_v_i && (stale_r != stale_max_lp);
        if (req_yumi) state_n = E_SEND_CMD;
      end
      E_SEND_CMD: begin
        io_cmd_v_o = 1'b1;
        if (io_cmd_ready_i) begin
          to_clear = 1'b1;
          state_n  = E_WAIT_RESP;
        end
      end
      E_WAIT_RESP: begin
        to_en = 1'b1;
        if (io_resp_v_i) begin
          resp_yumi = 1'b1;
          if (stale_r == '0) begin
            resp_capture = 1'b1;
            state_n      = E_SEND_LCE_CMD;
          end
        end else if (to_tc) begin
          timeout_hit = 1'b1;
          state_n     = E_SEND_LCE_CMD;
        end
      end
      E_SEND_LCE_CMD: begin
        lce_cmd_v_o = 1'b1;
        if (lce_cmd_ready_i) state_n = E_READY;
      end
      default: state_n = E_READY;
    endcase
    if (state_r != E_WAIT_RESP) resp_yumi = io_resp_v_i && (stale_r != '0);
  end

  assign stale_dec      = resp_yumi && (stale_r != '0);
  assign lce_req_yumi_o = reset_n_i & req_yumi;
  assign io_resp_yumi_o = reset_n_i & resp_yumi;
  assign busy_o         = (state_r != E_READY);
  assign timeout_o      = timeout_r;

  // Request capture, response capture, sticky timeout and stale-response bookkeeping.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      req_r       <= '0;
      resp_data_r <= '0;
      stale_r     <= '0;
      timeout_r   <= 1'b0;
    end else begin
      if (req_yumi)     req_r <= lce_req;
      if (resp_capture) resp_data_r <= io_resp.data[dword_width_p-1:0];
      if (timeout_hit) begin
        resp_data_r <= '1;
        timeout_r   <= 1'b1;
        if (stale_r != stale_max_lp) stale_r <= stale_r + 1'b1;
      end else if (stale_dec) begin
        stale_r <= stale_r - 1'b1;
      end
    end
  end

  // I/O command; zero while not valid.
  always_comb begin
    io_cmd = '0;
    if (io_cmd_v_o) begin
      io_cmd.msg_type       = (req_r.header.msg_type == e_lce_req_type_uc_wr) ? e_cce_mem_uc_wr : e_cce_mem_uc_rd;
      io_cmd.addr           = req_r.header.addr;
      io_cmd.size           = req_r.header.size;
      io_cmd.payload.lce_id = req_r.header.src_id;
      io_cmd.data           = dword_to_block(req_r.data);
    end
  end

  // LCE completion; zero while not valid.
  always_comb begin
    lce_cmd = '0;
    if (lce_cmd_v_o) begin
      lce_cmd.msg_type = (req_r.header.msg_type == e_lce_req_type_uc_wr) ? e_lce_cmd_uc_st_done : e_lce_cmd_uc_data;
      lce_cmd.dst_id   = req_r.header.src_id;
      lce_cmd.addr     = req_r.header.addr;
      lce_cmd.size     = req_r.header.size;
      lce_cmd.data     = dword_to_block(resp_data_r);
    end
  end

  assign io_cmd_o  = io_cmd;
  assign lce_cmd_o = lce_cmd;

  logic unused_resp;
  assign unused_resp = ^{io_resp.data[cce_block_width_p-1:dword_width_p], io_resp.payload,
                         io_resp.size, io_resp.addr, io_resp.msg_type};

  // A request routed to a different CCE is an integration error upstream.
  always @(posedge clk_i) begin
    if (reset_n_i && req_yumi) assert (lce_req.header.dst_id == cce_id_i);
  end

endmodule

// File: tb/tb_bp_io_uc_cce.sv
// Self-checking bench for bp_io_uc_cce with a transaction-level reference model.
module tb_bp_io_uc_cce;
  import bp_io_uc_cce_pkg::*;

  localparam int TO   = 16;
  localparam int SMAX = 7;
  localparam logic [3:0] CCE_ID = 4'h2;

  logic            clk_i = 1'b0;
  logic            reset_n_i;
  logic [3:0]      cce_id_i;
  bp_lce_cce_req_s lce_req_i;
  logic            lce_req_v_i, lce_req_yumi_o;
  bp_lce_cmd_s     lce_cmd_o;
  logic            lce_cmd_v_o, lce_cmd_ready_i;
  bp_cce_mem_msg_s io_cmd_o;
  logic            io_cmd_v_o, io_cmd_ready_i;
  bp_cce_mem_msg_s io_resp_i;
  logic            io_resp_v_i, io_resp_yumi_o;
  logic            busy_o, timeout_o;

  int n_chk  = 0;
  int n_pass = 0;
  int stale  = 0;     // outstanding late responses the DUT must still drop
  bit to_flag = 1'b0; // sticky timeout expectation

  bp_io_uc_cce #(.timeout_cycles_p(TO), .stale_max_p(SMAX)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .cce_id_i(cce_id_i),
    .lce_req_i(lce_req_i), .lce_req_v_i(lce_req_v_i), .lce_req_yumi_o(lce_req_yumi_o),
    .lce_cmd_o(lce_cmd_o), .lce_cmd_v_o(lce_cmd_v_o), .lce_cmd_ready_i(lce_cmd_ready_i),
    .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_ready_i(io_cmd_ready_i),
    .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_yumi_o(io_resp_yumi_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_req(input bit wr, input logic [39:0] addr, input logic [63:0] wdata, input logic [3:0] src);
    lce_req_i = '0;
    lce_req_i.header.msg_type = wr ? e_lce_req_type_uc_wr : e_lce_req_type_uc_rd;
    lce_req_i.header.addr     = addr;
    lce_req_i.header.size     = e_mem_msg_size_8;
    lce_req_i.header.src_id   = src;
    lce_req_i.header.dst_id   = CCE_ID;
    lce_req_i.data            = wdata;
  endtask

  // One full transaction. d<0 means the device never answers; 'late' stale responses come first.
  task automatic run_txn(input bit wr, input logic [39:0] addr, input logic [63:0] wdata,
                         input logic [3:0] src, input int cmd_wait, input int late, input int d,
                         input logic [63:0] rdata, input int lce_wait);
    bp_cce_mem_msg_s exp_io;
    bp_lce_cmd_s     exp_lce;
    logic [63:0]     exp_dword;
    bit              got = 1'b0;
    @(negedge clk_i);
    set_req(wr, addr, wdata, src);
    lce_req_v_i = 1'b1;
    #1 chk("req_yumi", lce_req_yumi_o, 1'b1);
    exp_io = '0;
    exp_io.msg_type       = wr ? e_cce_mem_uc_wr : e_cce_mem_uc_rd;
    exp_io.addr           = addr;
    exp_io.size           = e_mem_msg_size_8;
    exp_io.payload.lce_id = src;
    exp_io.data           = {64'h0, wdata};
    for (int i = 0; i <= cmd_wait; i++) begin
      @(negedge clk_i);
      io_cmd_ready_i = (i == cmd_wait);
      #1;
      chk("io_cmd_v", io_cmd_v_o, 1'b1);
      chk("io_cmd", io_cmd_o, exp_io);
      chk("req_blocked_cmd", lce_req_yumi_o, 1'b0);
    end
    for (int c = 0; c < TO && !got; c++) begin
      @(negedge clk_i);
      io_cmd_ready_i = 1'b0;
      io_resp_v_i    = 1'b0;
      io_resp_i      = '0;
      if (c < late) begin
        io_resp_v_i    = 1'b1;
        io_resp_i.data = {64'hA5A5_0000_0000_0000, 64'h1};
      end else if (c == d) begin
        io_resp_v_i    = 1'b1;
        io_resp_i.data = {64'h5A5A_FFFF_0000_1111, rdata};
      end
      #1;
      chk("io_cmd_v_off", io_cmd_v_o, 1'b0);
      chk("resp_yumi", io_resp_yumi_o, io_resp_v_i);
      if (c < late) stale--;
      else if (c == d) got = 1'b1;
    end
    if (got) exp_dword = rdata;
    else begin
      exp_dword = '1;
      stale     = (stale < SMAX) ? stale + 1 : SMAX;
      to_flag   = 1'b1;
    end
    exp_lce = '0;
    exp_lce.msg_type = wr ? e_lce_cmd_uc_st_done : e_lce_cmd_uc_data;
    exp_lce.dst_id   = src;
    exp_lce.addr     = addr;
    exp_lce.size     = e_mem_msg_size_8;
    exp_lce.data     = {64'h0, exp_dword};
    for (int i = 0; i <= lce_wait; i++) begin
      @(negedge clk_i);
      io_resp_v_i     = 1'b0;
      io_resp_i       = '0;
      lce_cmd_ready_i = (i == lce_wait);
      #1;
      chk("lce_cmd_v", lce_cmd_v_o, 1'b1);
      chk("lce_cmd", lce_cmd_o, exp_lce);
      chk("timeout_o", timeout_o, to_flag);
      chk("req_blocked_lce", lce_req_yumi_o, 1'b0);
    end
    @(negedge clk_i);
    lce_cmd_ready_i = 1'b0;
    lce_req_v_i     = 1'b0;
    #1;
    chk("busy_done", busy_o, 1'b0);
    chk("lce_cmd_v_off", lce_cmd_v_o, 1'b0);
  endtask

  initial begin
    reset_n_i = 1'b0; cce_id_i = CCE_ID;
    lce_req_i = '0; lce_req_v_i = 1'b0; lce_cmd_ready_i = 1'b0;
    io_cmd_ready_i = 1'b0; io_resp_i = '0; io_resp_v_i = 1'b0;
    #2;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_timeout", timeout_o, 1'b0);
    chk("rst_io_cmd_v", io_cmd_v_o, 1'b0);
    chk("rst_lce_cmd_v", lce_cmd_v_o, 1'b0);
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;

    // Response with no stale debt outside WAIT_RESP must be left alone.
    @(negedge clk_i);
    io_resp_v_i = 1'b1;
    #1 chk("idle_resp_not_taken", io_resp_yumi_o, 1'b0);
    @(negedge clk_i);
    io_resp_v_i = 1'b0;

    // Directed read and write paths.
    run_txn(1'b0, 40'h00_0010_0000, 64'h0, 4'd3, 0, 0, 4, 64'hDEAD_BEEF_0123_4567, 0);
    run_txn(1'b1, 40'h00_0020_0008, 64'h55, 4'd3, 0, 0, 2, 64'h0, 0);
    // Backpressure on both outgoing channels.
    run_txn(1'b0, 40'h00_0030_0010, 64'h0, 4'd5, 10, 0, 3, 64'h1234_5678_9ABC_DEF0, 10);

    // Randomized transactions.
    for (int k = 0; k < 10; k++) begin
      run_txn(1'($urandom_range(0, 1)), {8'h0, $urandom() & 32'hFFFF_FFF8}, {$urandom(), $urandom()},
              4'($urandom_range(0, 15)), $urandom_range(0, 3), 0, $urandom_range(0, TO-2),
              {$urandom(), $urandom()}, $urandom_range(0, 3));
    end

    // Response exactly at terminal count wins.
    run_txn(1'b0, 40'h00_0040_0000, 64'h0, 4'd1, 0, 0, TO-1, 64'hCAFE_F00D_0000_0042, 0);
    chk("no_timeout_on_tie", timeout_o, 1'b0);

    // Timeout, then a late response to drop before the real one.
    run_txn(1'b0, 40'h00_0050_0000, 64'h0, 4'd3, 0, 0, -1, 64'h0, 0);
    run_txn(1'b0, 40'h00_0050_0008, 64'h0, 4'd3, 0, 1, 3, 64'h2, 0);

    // Saturate the stale counter with consecutive timeouts.
    for (int k = 0; k < SMAX; k++)
      run_txn(1'b1, 40'h00_0060_0000 + 40'(k * 8), 64'(k), 4'd7, 0, 0, -1, 64'h0, 0);
    @(negedge clk_i);
    set_req(1'b0, 40'h00_0070_0000, 64'h0, 4'd4);
    lce_req_v_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("req_blocked_stale", lce_req_yumi_o, (stale == SMAX) ? 1'b0 : 1'b1);
      @(negedge clk_i);
    end
    io_resp_v_i = 1'b1;
    io_resp_i.data = 128'h77;
    #1;
    chk("drain_idle", io_resp_yumi_o, 1'b1);
    chk("req_still_blocked", lce_req_yumi_o, 1'b0);
    stale--;
    @(negedge clk_i);
    io_resp_v_i = 1'b0; io_resp_i = '0; lce_req_v_i = 1'b0;
    #1 chk("busy_idle", busy_o, 1'b0);
    run_txn(1'b0, 40'h00_0070_0000, 64'h0, 4'd4, 0, stale, stale + 2, 64'hBEEF, 0);

    // Reset while waiting for a response.
    @(negedge clk_i);
    set_req(1'b1, 40'h00_0080_0000, 64'h99, 4'd6);
    lce_req_v_i = 1'b1;
    @(negedge clk_i);
    lce_req_v_i = 1'b0; io_cmd_ready_i = 1'b1;
    @(negedge clk_i);
    io_cmd_ready_i = 1'b0;
    #1 chk("busy_in_wait", busy_o, 1'b1);
    #1;
    reset_n_i = 1'b0; io_resp_v_i = 1'b1; lce_req_v_i = 1'b1;
    #1;
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_timeout", timeout_o, 1'b0);
    chk("arst_req_yumi", lce_req_yumi_o, 1'b0);
    chk("arst_resp_yumi", io_resp_yumi_o, 1'b0);
    chk("arst_io_cmd", {io_cmd_v_o, io_cmd_o}, '0);
    chk("arst_lce_cmd", {lce_cmd_v_o, lce_cmd_o}, '0);
    stale = 0; to_flag = 1'b0;
    @(negedge clk_i);
    io_resp_v_i = 1'b0; lce_req_v_i = 1'b0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    #1 chk("post_rst_busy", busy_o, 1'b0);
    run_txn(1'b0, 40'h00_0090_0000, 64'h0, 4'd2, 1, 0, 5, 64'h0BAD_CAFE, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
